ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter; companion to the PS/2 receiver on the same ps2c/ps2d pins.
- Takes a byte from the command logic, e.g. keyboard LED or enable-reporting commands.
- Performs the request-to-send inhibit, then shifts start, data, odd parity and stop bits on device-generated falling edges.
- Drives open-drain enables for the top-level tristate buffers.
- tx_idle gates the receiver's rx_en so the receiver never captures our own frame.

---
 rtl/ps2_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, then start/data/odd-parity/stop on device clock.
// Optional device-acknowledge check is enabled by defining PS2_TX_ACK_CHECK_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2d_in,
  input  logic       ps2c_in,
  output logic       ps2d_out,
  output logic       ps2c_out,
  output logic       tri_d,
  output logic       tri_c,
  output logic       tx_idle,
  output logic       tx_done_tick,
`ifdef PS2_TX_ACK_CHECK_EN
  output logic       ack_err,
`endif
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(INHIBIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            n_q, n_d;
  logic [8:0]            b_q, b_d;
  logic                  armed_q;
  logic                  fall_edge;

  // Handshake: wr_ps2 is a one-cycle strobe with no backpressure; it is taken only
  // while tx_idle=1 and never in the first cycle after reset release, otherwise dropped.
  logic wr_accept;
  assign wr_accept = wr_ps2 & armed_q;

  assign filt_d    = {ps2c_in, filt_q[FILTER_LEN-1:1]};
  assign fclk_d    = (filt_q == '1) ? 1'b1 : (filt_q == '0) ? 1'b0 : fclk_q;
  assign fall_edge = fclk_q & ~fclk_d;

  assign ps2c_out  = 1'b0;
  assign dbg_state = state_q;

`ifdef PS2_TX_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign ack_err = ack_err_q;
`else
  logic unused_ps2d;
  assign unused_ps2d = ps2d_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      filt_q    <= '0;
      fclk_q    <= 1'b0;
      cnt_q     <= '0;
      n_q       <= '0;
      b_q       <= '0;
      armed_q   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      fclk_q    <= fclk_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      b_q       <= b_d;
      armed_q   <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_err_q <= ack_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    b_d          = b_q;
    tri_c        = 1'b0;
    tri_d        = 1'b0;
    ps2d_out     = 1'b1;
    tx_idle      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_err_d    = ack_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_idle = 1'b1;
        if (wr_accept) begin
          b_d     = {~^din, din};
          cnt_d   = CW'(INHIBIT_CYCLES - 1);
          state_d = S_RTS;
`ifdef PS2_TX_ACK_CHECK_EN
          ack_err_d = 1'b0;
`endif
        end
      end
      S_RTS: begin
        tri_c = 1'b1;
        if (cnt_q == '0) state_d = S_START;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_START: begin
        tri_d    = 1'b1;
        ps2d_out = 1'b0;
        if (fall_edge) begin
          n_d     = 4'd8;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tri_d    = 1'b1;
        ps2d_out = b_q[0];
        if (fall_edge) begin
          b_d = {1'b0, b_q[8:1]};
          if (n_q == 4'd0) state_d = S_STOP;
          else             n_d     = n_q - 4'd1;
        end
      end
      S_STOP: begin
        // Released data line is the stop bit.
        if (fall_edge) begin
`ifdef PS2_TX_ACK_CHECK_EN
          state_d = S_ACK;
`else
          state_d      = S_IDLE;
          tx_done_tick = 1'b1;
`endif
        end
      end
`ifdef PS2_TX_ACK_CHECK_EN
      S_ACK: begin
        if (fall_edge) begin
          ack_err_d    = ps2d_in;
          state_d      = S_IDLE;
          tx_done_tick = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out and compares them to
// frames built from the byte value (start, data LSB first, odd parity, stop).
module tb_ps2_tx;

  localparam int INH = 20;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam int NE = 12;
`else
  localparam int NE = 11;
`endif

  logic       clk;
  logic       rst;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2d_in, ps2c_in;
  logic       ps2d_out, ps2c_out, tri_d, tri_c, tx_idle, tx_done_tick;
  logic [2:0] dbg_state;
`ifdef PS2_TX_ACK_CHECK_EN
  logic       ack_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Open-drain wiring of both pins with pull-ups.
  assign ps2c_in = (tri_c ? ps2c_out : 1'b1) & dev_clk;
  assign ps2d_in = (tri_d ? ps2d_out : 1'b1) & dev_data;

  ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(8)) dut (
    .clk(clk), .rst(rst), .wr_ps2(wr_ps2), .din(din),
    .ps2d_in(ps2d_in), .ps2c_in(ps2c_in),
    .ps2d_out(ps2d_out), .ps2c_out(ps2c_out), .tri_d(tri_d), .tri_c(tri_c),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick),
`ifdef PS2_TX_ACK_CHECK_EN
    .ack_err(ack_err),
`endif
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Expected line values seen by the device just before each falling edge.
  function automatic logic [11:0] frame_bits(input logic [7:0] d);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return f;
  endfunction

  task automatic dev_pulse(input bit glitch, input bit busy_wr, input logic d_drive, output logic smp);
    repeat (5) @(negedge clk);
    if (glitch) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
    end else begin
      repeat (3) @(negedge clk);
    end
    if (busy_wr) begin
      wr_ps2 = 1'b1;
      din    = ~din;
      @(negedge clk);
      wr_ps2 = 1'b0;
    end else begin
      @(negedge clk);
    end
    repeat (11) @(negedge clk);
    smp      = ps2d_in;
    dev_data = d_drive;
    dev_clk  = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input int glitch_at, input int busy_at,
                           input logic ack_val);
    logic [11:0] got, exp;
    logic s;
    int rts_n, d0;
    exp = frame_bits(d);
    got = '1;
    d0  = done_cnt;
    write_byte(d);
    checks++;
    if (tx_idle !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_write: tx_idle=%b required 0", tx_idle);
    end
`ifdef PS2_TX_ACK_CHECK_EN
    checks++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_err_clear: ack_err=%b required 0", ack_err);
    end
`endif
    rts_n = 0;
    while (tri_c === 1'b1 && rts_n < 200) begin
      rts_n++;
      @(negedge clk);
    end
    checks++;
    if (rts_n !== INH) begin
      errors++;
      $display("FAIL inhibit_len: tri_c low cycles=%0d required %0d", rts_n, INH);
    end
    checks++;
    if (tri_c !== 1'b0 || tri_d !== 1'b1 || ps2d_out !== 1'b0) begin
      errors++;
      $display("FAIL start_bit: tri_c=%b tri_d=%b ps2d_out=%b required 0 1 0", tri_c, tri_d, ps2d_out);
    end
    for (int k = 1; k <= NE; k++) begin
      dev_pulse(k == glitch_at, k == busy_at, (k == 12) ? ack_val : 1'b1, s);
      got[k-1] = s;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL frame_%02h: line bits=%b required %b", d, got, exp);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL done_tick_%02h: pulses=%0d required 1", d, done_cnt - d0);
    end
    checks++;
    if (tx_idle !== 1'b1 || tri_d !== 1'b0 || tri_c !== 1'b0) begin
      errors++;
      $display("FAIL end_idle_%02h: tx_idle=%b tri_d=%b tri_c=%b required 1 0 0", d, tx_idle, tri_d, tri_c);
    end
`ifdef PS2_TX_ACK_CHECK_EN
    checks++;
    if (ack_err !== ack_val) begin
      errors++;
      $display("FAIL ack_err: ack_err=%b required %b", ack_err, ack_val);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dev_clk = ~dev_clk;
      wr_ps2  = (i == 10);
    end
    wr_ps2 = 1'b0;
    #1;
    checks++;
    if (tri_c !== 1'b0 || tri_d !== 1'b0 || ps2c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_tri: tri_c=%b tri_d=%b ps2c_out=%b required 0 0 0", tri_c, tri_d, ps2c_out);
    end
    checks++;
    if (ps2d_out !== 1'b1 || tx_idle !== 1'b1 || tx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: ps2d_out=%b tx_idle=%b done=%b required 1 1 0", ps2d_out, tx_idle, tx_done_tick);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_done: pulses=%0d required 0", done_cnt);
    end
    @(negedge clk);
    dev_clk = 1'b1;
    rst     = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_inhibit_frame();
    run_frame(8'hF4, 0, 0, 1'b0);
  endtask

  task automatic test_parity();
    run_frame(8'hFF, 0, 0, 1'b0);
    run_frame(8'hED, 0, 0, 1'b0);
    run_frame(8'h00, 0, 0, 1'b0);
  endtask

  task automatic test_busy_glitch();
    run_frame(8'($urandom_range(0, 255)), 4, 6, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic s;
    int n, hits, d0;
    d0 = done_cnt;
    write_byte(8'($urandom_range(0, 255)));
    n = 0;
    while (tri_c === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) dev_pulse(1'b0, 1'b0, 1'b1, s);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tri_c !== 1'b0 || tri_d !== 1'b0 || tx_idle !== 1'b1 || ps2d_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: tri_c=%b tri_d=%b tx_idle=%b ps2d_out=%b required 0 0 1 1",
               tri_c, tri_d, tx_idle, ps2d_out);
    end
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    wr_ps2 = 1'b1;
    din    = 8'h5A;
    @(negedge clk);
    wr_ps2 = 1'b0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (tri_c !== 1'b0 || tx_idle !== 1'b1) hits++;
      @(negedge clk);
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL wr_at_reset_release: busy cycles=%0d required 0", hits);
    end
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_mid_done: pulses=%0d required 0", done_cnt - d0);
    end
  endtask

  task automatic test_ack();
    run_frame(8'($urandom_range(0, 255)), 0, 0, 1'b1);
    run_frame(8'($urandom_range(0, 255)), 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_frame(8'($urandom_range(0, 255)), 0, 0, 1'b0);
  endtask

  initial begin
    rst      = 1'b0;
    wr_ps2   = 1'b0;
    din      = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    test_reset();
    test_inhibit_frame();
    test_parity();
    test_busy_glitch();
    test_reset_mid();
    test_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
